// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file used by decode and writeback.
package regfile_pkg;

    // Clear sequencer states: sweeping zeros into storage, then live.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_XLEN_DEFAULT  = 32;
    localparam int RF_NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: priority bypass mux (zero reg, write port 1,
// write port 0, storage) feeding an output register. Held at zero while the
// parent is in reset or running its clear sweep.
module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic [AW-1:0]   i_raddr,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_wen0,
    input  logic [AW-1:0]   i_waddr0,
    input  logic [XLEN-1:0] i_wdata0,
    input  logic            i_wen1,
    input  logic [AW-1:0]   i_waddr1,
    input  logic [XLEN-1:0] i_wdata1,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_rdata;

    // Register the first matching source so reads see this edge's writes.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_rdata <= '0;
        end else if ((ZERO_REG != 0) && (i_raddr == '0)) begin
            r_rdata <= '0;
        end else if (i_wen1 && (i_waddr1 == i_raddr)) begin
            r_rdata <= i_wdata1;
        end else if (i_wen0 && (i_waddr0 == i_raddr)) begin
            r_rdata <= i_wdata0;
        end else begin
            r_rdata <= i_stored;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered read ports with write-first
// bypass, two write ports (port 1 wins on address conflict), optional
// hardwired-zero register 0, and a post-reset clear sweep gating 'ready'.
// Handshake: there is none on the data ports; callers must not rely on any
// read or write until 'ready' is high. Writes presented while 'ready' is low
// are discarded, and read data is held at zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int   XLEN     = RF_XLEN_DEFAULT,
    parameter int   NREGS    = RF_NREGS_DEFAULT,
    parameter int   NREAD    = 2,
    parameter int   ZERO_REG = 1,
    localparam int  AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic                  wen0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  wen1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    output rf_state_t             dbg_state,
    output logic [AW-1:0]         dbg_clr_idx
);

    rf_state_t       r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    logic [XLEN-1:0] r_regs [NREGS];

    logic w_clear;
    logic w_run;
    logic w_wr0_ok;
    logic w_wr1_ok;

    assign w_clear  = (r_state == RF_CLEAR);
    assign w_run    = (r_state == RF_RUN) && !rst;
    assign w_wr0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_wr1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Clear sequencer: reset restarts the sweep; last index cleared -> live.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_clr_idx <= r_clr_idx + AW'(1);
                    if (r_clr_idx == AW'(NREGS - 1)) begin
                        r_state <= RF_RUN;
                        r_ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= RF_CLEAR;
                    r_clr_idx <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: sweep zeros while clearing, else commit writes with
    // port 1 assigned last so it overrides port 0 on the same address.
    always_ff @(posedge clk) begin
        if (!rst && w_clear) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_run) begin
            if (w_wr0_ok) begin
                r_regs[waddr0] <= wdata0;
            end
            if (w_wr1_ok) begin
                r_regs[waddr1] <= wdata1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0] w_raddr;
            assign w_raddr = raddr[gi*AW +: AW];

            regfile_rd_port #(
                .XLEN     (XLEN),
                .AW       (AW),
                .ZERO_REG (ZERO_REG)
            ) u_rd_port (
                .i_clk    (clk),
                .i_rst    (rst),
                .i_clear  (w_clear),
                .i_raddr  (w_raddr),
                .i_stored (r_regs[w_raddr]),
                .i_wen0   (wen0),
                .i_waddr0 (waddr0),
                .i_wdata0 (wdata0),
                .i_wen1   (wen1),
                .i_waddr1 (waddr1),
                .i_wdata1 (wdata1),
                .o_rdata  (rdata[gi*XLEN +: XLEN])
            );
        end
    endgenerate

    assign ready       = r_ready;
    assign dbg_state   = r_state;
    assign dbg_clr_idx = r_clr_idx;

endmodule
